// File: rtl/lamp_count_encoder.sv
`timescale 1ns/1ps
// Debounces 16 lamp-sense lines, counts lit lamps, and offers {overflow, active_lights} on valid/ready.
// Latency: DEBOUNCE_CYCLES+2 cycles from a clean input step to valid (sample_en held high).
// Backpressure: outputs hold while stalled; latest code wins and intermediate counts are dropped.
module lamp_count_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] lamp_in,
    input  logic        sample_en,
    output logic [3:0]  active_lights,
    output logic        overflow,
    output logic        valid,
    input  logic        ready
);

    localparam logic [3:0] LAST_CNT = 4'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_IDLE,
        ST_PEND
    } state_t;

    logic [15:0]      stable_q, stable_d;
    logic [15:0][3:0] cnt_q, cnt_d;
    logic [4:0]       pop_cnt;
    logic [4:0]       code_q, code_d;
    logic [4:0]       out_q;
    logic [4:0]       deliv_q;
    state_t           state_q;

    // Each counter tracks consecutive enabled samples that disagree with the debounced bit.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < 16; i++) begin
            if (lamp_in[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (sample_en) begin
                if (cnt_q[i] == LAST_CNT) begin
                    stable_d[i] = lamp_in[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < 16; i++) begin
            pop_cnt = pop_cnt + 5'(stable_q[i]);
        end
        code_d[4]   = (pop_cnt == 5'd16);
        code_d[3:0] = pop_cnt[4] ? 4'hF : pop_cnt[3:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q <= '0;
            cnt_q    <= '0;
            code_q   <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
        end
    end

    // deliv_q remembers the last code actually accepted, so a count that wanders
    // away and back before being loaded never produces a duplicate transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            deliv_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (code_q != deliv_q) begin
                        out_q   <= code_q;
                        state_q <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (ready) begin
                        deliv_q <= out_q;
                        if (code_q != out_q) begin
                            out_q <= code_q;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign valid         = (state_q == ST_PEND);
    assign overflow      = out_q[4];
    assign active_lights = out_q[3:0];

endmodule

// File: tb/tb_lamp_count_encoder.sv
`timescale 1ns/1ps
// Bench for lamp_count_encoder: directed vector table, hand sequences, and a randomized run
// checked every cycle against a sample-counting reference model.
module tb_lamp_count_encoder;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] lamp_in;
    logic        sample_en;
    logic        ready;
    logic [3:0]  active_lights;
    logic        overflow;
    logic        valid;

    int checks   = 0;
    int failures = 0;

    // reference model state
    bit [15:0] m_stable;
    int        m_run [16];
    bit [4:0]  m_code;
    bit [4:0]  m_out;
    bit [4:0]  m_deliv;
    bit        m_valid;

    lamp_count_encoder #(.DEBOUNCE_CYCLES(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .lamp_in      (lamp_in),
        .sample_en    (sample_en),
        .active_lights(active_lights),
        .overflow     (overflow),
        .valid        (valid),
        .ready        (ready)
    );

    always #5 clk = ~clk;

    function automatic bit [4:0] code_of(input bit [15:0] v);
        int       c;
        bit [4:0] r;
        c       = $countones(v);
        r[4]    = (c == 16);
        r[3:0]  = (c >= 15) ? 4'd15 : 4'(c);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Advances the model by one clock edge using the inputs about to be sampled.
    task automatic model_step(input bit [15:0] l, input bit s, input bit r, input bit rs);
        bit [4:0] next_code;
        if (rs) begin
            m_stable = '0;
            foreach (m_run[i]) m_run[i] = 0;
            m_code  = '0;
            m_out   = '0;
            m_deliv = '0;
            m_valid = 1'b0;
            return;
        end
        if (!m_valid) begin
            if (m_code != m_deliv) begin
                m_out   = m_code;
                m_valid = 1'b1;
            end
        end else if (r) begin
            m_deliv = m_out;
            if (m_code != m_out) m_out = m_code;
            else m_valid = 1'b0;
        end
        next_code = code_of(m_stable);
        for (int i = 0; i < 16; i++) begin
            if (l[i] == m_stable[i]) begin
                m_run[i] = 0;
            end else if (s) begin
                m_run[i]++;
                if (m_run[i] >= D) begin
                    m_stable[i] = l[i];
                    m_run[i]    = 0;
                end
            end
        end
        m_code = next_code;
    endtask

    task automatic tick(input logic [15:0] l, input logic s, input logic r, input logic rs);
        lamp_in   = l;
        sample_en = s;
        ready     = r;
        rst       = rs;
        model_step(l, s, r, rs);
        @(posedge clk);
        @(negedge clk);
        check("model_valid", valid, m_valid);
        check("model_active_lights", active_lights, m_out[3:0]);
        check("model_overflow", overflow, m_out[4]);
    endtask

    typedef struct {
        logic [15:0] lamp;
        int          pulses;
        logic [3:0]  al;
        logic        ovf;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int first;
        int pulses;
        logic [3:0] cap_al;
        logic cap_ovf;
        logic [15:0] rl;

        vecs[0]  = '{16'h0000, 1, 4'd0,  1'b0};
        vecs[1]  = '{16'h0002, 1, 4'd1,  1'b0};
        vecs[2]  = '{16'h000A, 1, 4'd2,  1'b0};
        vecs[3]  = '{16'h000E, 1, 4'd3,  1'b0};
        vecs[4]  = '{16'h0003, 1, 4'd2,  1'b0};
        vecs[5]  = '{16'h0005, 0, 4'd0,  1'b0};
        vecs[6]  = '{16'h0002, 1, 4'd1,  1'b0};
        vecs[7]  = '{16'h0002, 0, 4'd0,  1'b0};
        vecs[8]  = '{16'hFFFF, 1, 4'd15, 1'b1};
        vecs[9]  = '{16'h7FFF, 1, 4'd15, 1'b0};
        vecs[10] = '{16'h0000, 1, 4'd0,  1'b0};

        // reset with all lamps lit, then time the first transfer
        for (int k = 0; k < 3; k++) begin
            tick(16'hFFFF, 1'b1, 1'b1, 1'b1);
            check("reset_valid", valid, 1'b0);
            check("reset_active_lights", active_lights, 4'd0);
            check("reset_overflow", overflow, 1'b0);
        end
        first = -1;
        for (int k = 1; k <= D + 4; k++) begin
            tick(16'hFFFF, 1'b1, 1'b1, 1'b0);
            if (valid && first < 0) begin
                first   = k;
                cap_al  = active_lights;
                cap_ovf = overflow;
            end
        end
        check("post_reset_latency", first, D + 2);
        if (first >= 0) begin
            check("post_reset_al", cap_al, 4'd15);
            check("post_reset_ovf", cap_ovf, 1'b1);
        end

        // directed table, ready held high
        foreach (vecs[v]) begin
            first  = -1;
            pulses = 0;
            for (int k = 1; k <= D + 4; k++) begin
                tick(vecs[v].lamp, 1'b1, 1'b1, 1'b0);
                if (valid) begin
                    pulses++;
                    if (first < 0) begin
                        first   = k;
                        cap_al  = active_lights;
                        cap_ovf = overflow;
                    end
                end
            end
            check($sformatf("vec%0d_pulses", v), pulses, vecs[v].pulses);
            if (vecs[v].pulses > 0 && first >= 0) begin
                check($sformatf("vec%0d_latency", v), first, D + 2);
                check($sformatf("vec%0d_al", v), cap_al, vecs[v].al);
                check($sformatf("vec%0d_ovf", v), cap_ovf, vecs[v].ovf);
            end
        end

        // glitches shorter than the debounce window never propagate
        pulses = 0;
        for (int k = 0; k < 3; k++) begin tick(16'h0020, 1'b1, 1'b1, 1'b0); pulses += int'(valid); end
        tick(16'h0000, 1'b1, 1'b1, 1'b0); pulses += int'(valid);
        for (int k = 0; k < 3; k++) begin tick(16'h0020, 1'b1, 1'b1, 1'b0); pulses += int'(valid); end
        for (int k = 0; k < 8; k++) begin tick(16'h0000, 1'b1, 1'b1, 1'b0); pulses += int'(valid); end
        check("glitch_pulses", pulses, 0);

        // sample_en low freezes the debounce count
        for (int k = 0; k < 2; k++) tick(16'h0020, 1'b1, 1'b1, 1'b0);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin tick(16'h0020, 1'b0, 1'b1, 1'b0); pulses += int'(valid); end
        check("gated_pulses", pulses, 0);
        first = -1;
        for (int k = 1; k <= 8; k++) begin
            tick(16'h0020, 1'b1, 1'b1, 1'b0);
            if (valid && first < 0) begin first = k; cap_al = active_lights; end
        end
        check("gated_resume_latency", first, 4);
        check("gated_resume_al", cap_al, 4'd1);
        for (int k = 0; k < D + 4; k++) tick(16'h0000, 1'b1, 1'b1, 1'b0);

        // backpressure: latest value wins
        first = -1;
        for (int k = 1; k <= D + 4; k++) begin
            tick(16'h000F, 1'b1, 1'b0, 1'b0);
            if (valid && first < 0) first = k;
        end
        check("stall_latency", first, D + 2);
        for (int k = 0; k < 8; k++) begin
            tick(16'h00FF, 1'b1, 1'b0, 1'b0);
            check("stall_valid_hold", valid, 1'b1);
            check("stall_al_hold", active_lights, 4'd4);
        end
        tick(16'h00FF, 1'b1, 1'b1, 1'b0);
        check("b2b_valid", valid, 1'b1);
        check("b2b_al", active_lights, 4'd8);
        tick(16'h00FF, 1'b1, 1'b1, 1'b0);
        check("b2b_drop", valid, 1'b0);

        // reset while a value is pending
        for (int k = 0; k < D + 2; k++) tick(16'h0003, 1'b1, 1'b0, 1'b0);
        check("pend_before_rst", valid, 1'b1);
        tick(16'h0003, 1'b1, 1'b0, 1'b1);
        check("rst_pend_valid", valid, 1'b0);
        check("rst_pend_al", active_lights, 4'd0);
        check("rst_pend_ovf", overflow, 1'b0);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin tick(16'h0000, 1'b1, 1'b1, 1'b0); pulses += int'(valid); end
        check("post_rst_pulses", pulses, 0);

        // randomized run against the model
        rl = 16'h0000;
        for (int k = 0; k < 3000; k++) begin
            case ($urandom_range(0, 19))
                0:       rl = $urandom();
                1:       rl = 16'hFFFF;
                2:       rl = 16'h7FFF;
                3, 4:    rl = rl ^ (16'h1 << $urandom_range(0, 15));
                default: ;
            endcase
            tick(rl, ($urandom_range(0, 4) != 0), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 199) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lamp_count_encoder.md
# lamp_count_encoder

Reverse path of the lamp-state decoder. Monitors the 16 physical lamp status lines, debounces each line, counts the lit lamps, and reports the count as a 4-bit `active_lights` code with a valid/ready handshake. Sits between the lamp-sense inputs and the controller that consumes the active-lights code.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive differing samples required before a lamp bit changes state. Legal range 1..15.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `lamp_in`  in  16  raw lamp status, bit i = lamp i lit. Asynchronous to meaning but sampled on `clk`.
- `sample_en`  in  1  sampling strobe; debounce counters advance only when high.
- `active_lights`  out  4  debounced lit-lamp count, saturated at 15.
- `overflow`  out  1  high when all 16 lamps are lit (count = 16).
- `valid`  out  1  `{overflow, active_lights}` holds a new value.
- `ready`  in  1  consumer accepts the value when high together with `valid`.

## Operation

- Reset values: `active_lights`=0, `overflow`=0, `valid`=0; the internal stable vector, per-bit counters, popcount register, and delivered value are all 0.
- Per-lamp debounce (16 independent instances):
  - `lamp_in[i] == stable[i]`: counter[i] clears to 0.
  - Differing and `sample_en`=1: counter[i] increments. On the sample where counter[i] == `DEBOUNCE_CYCLES-1`, `stable[i]` takes `lamp_in[i]` and counter[i] clears.
  - Differing and `sample_en`=0: counter[i] holds.
  - With `DEBOUNCE_CYCLES`=1, the first differing sample updates `stable[i]`.
- Count stage: the popcount of `stable` (0..16) is registered each cycle as code = `{count==16, min(count,15)}`.
- Output stage (states IDLE and PEND):
  - IDLE (`valid`=0): if the registered code differs from the last delivered code, load it onto the outputs, assert `valid`, and go to PEND.
  - PEND (`valid`=1): outputs hold stable while `ready`=0. On `valid && ready`, the transfer completes and the delivered code takes the transferred value. On that same edge:
    - If the registered code differs from the transferred one, load the new code and keep `valid` high (back-to-back transfer).
    - Otherwise drop `valid` and return to IDLE.
- Backpressure policy: latest value wins. Intermediate counts that occur during a stall are dropped. Only the code present at the transfer edge is reissued.
- Saturation: 16 lit lamps reports `active_lights`=15, `overflow`=1. 15 lit lamps reports 15 with `overflow`=0. These are distinct codes, so a transition between them produces a transfer.
- A change that returns to the delivered code before it is loaded produces no transfer.
- Reset mid-operation: all state clears at the next edge. `valid` goes low regardless of `ready`, and no transfer is counted on that edge.

## Timing

- Edge k: the Nth consecutive differing sample updates `stable`.
- Edge k+1: the popcount register updates.
- Edge k+2: `valid` rises with the new code, provided the block is in IDLE.
- Minimum latency from a clean input step (with `sample_en` tied high) to `valid` is `DEBOUNCE_CYCLES`+2 cycles.
- With `ready` held high, `valid` is a single-cycle pulse per change. Back-to-back transfers run at up to one per cycle.
- `valid` never deasserts without a transfer, except on reset.

## Test plan

1. Reset with `lamp_in`=16'hFFFF → outputs 0 and `valid`=0 during reset. After release, a transfer of 15/`overflow`=1 occurs `DEBOUNCE_CYCLES`+2 cycles later.
2. `lamp_in`=16'h0002, `sample_en`=1, `ready`=1, default parameter → `valid` pulses for one cycle on the 6th edge after the step, with `active_lights`=1. Then 16'h000A gives 2, 16'h000E gives 3, 16'h0003 gives 2 (each its own pulse); 16'h0002 repeated gives no pulse.
3. Glitch: bit 5 high for 3 samples then low → no `valid`, and `stable` is unchanged. Gate `sample_en` low mid-run and confirm the counters hold.
4. 16'hFFFF → 15/`overflow`=1. Then 16'h7FFF → 15/`overflow`=0, with a separate `valid` issued.
5. Backpressure: with `ready`=0, step to 16'h000F → `valid` with 4, held. Step to 16'h00FF while stalled → outputs stay 4. Raise `ready` → 4 transfers, then 8 back-to-back on the next cycle.
6. Assert `rst` while `valid`=1 and `ready`=0 → `valid`=0, `active_lights`=0, `overflow`=0 at the next edge, and no spurious transfer after release when `lamp_in`=0.
